// File: rtl/brz_slice_arb_pkg.sv
// Shared types for the brz_slice_arbiter slice: FSM state encoding,
// requester index type and the helper used by the round-robin picker.
package brz_slice_arb_pkg;

    localparam int N_REQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ACK   = 2'd2,
        RTZ   = 2'd3
    } arb_state_t;

    typedef logic req_idx_t;

    // With only two requesters, the "other" consumer is the bitwise inverse.
    function automatic req_idx_t otherIdx(input req_idx_t idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/brz_rr_pick.sv
// Two-way round-robin picker. A lone request always wins. When both
// consumers request at once, the one that was not served last wins.
module brz_rr_pick
    import brz_slice_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  req_idx_t         last,
    output logic             valid,
    output req_idx_t         idx
);

    // Choose a winner from the current request vector and last-served index.
    always_comb begin
        valid = |req;
        idx   = 1'b0;
        if (req == 2'b11) begin
            idx = otherIdx(last);
        end else if (req[1]) begin
            idx = 1'b1;
        end
    end

endmodule

// File: rtl/brz_slice_arbiter.sv
// Two-consumer arbiter sharing one 4-phase pull channel. Each consumer
// receives its own bit-slice of the shared producer word.
// Optional feature macro: BRZ_SLICE_CAPTURE_EN. When it is defined, the
// slices are captured on the FETCH->ACK edge, the producer request is
// released as ACK is entered, and consumers see the captured data.
module brz_slice_arbiter
    import brz_slice_arb_pkg::*;
#(
    parameter int IN_W  = 18,
    parameter int OUT_W = 16,
    parameter int LOW0  = 1,
    parameter int LOW1  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             out0_0r,
    output logic             out0_0a,
    output logic [OUT_W-1:0] out0_0d,
    input  logic             out1_0r,
    output logic             out1_0a,
    output logic [OUT_W-1:0] out1_0d,
    output logic             inp_0r,
    input  logic             inp_0a,
    input  logic [IN_W-1:0]  inp_0d,
    output logic             busy,
    output logic             grant,
    output logic [CNT_W-1:0] xfer_cnt
);

    arb_state_t       r_state;
    arb_state_t       w_stateNext;
    logic             r_inpReq;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_busy;
    req_idx_t         r_grant;
    req_idx_t         r_last;
    logic [CNT_W-1:0] r_cnt;

    logic             w_inpReqNext;
    logic             w_ack0Next;
    logic             w_ack1Next;
    logic             w_busyNext;
    req_idx_t         w_grantNext;
    req_idx_t         w_lastNext;
    logic [CNT_W-1:0] w_cntNext;

    logic             w_pickValid;
    req_idx_t         w_pickIdx;
    logic             w_grantReq;
    logic [OUT_W-1:0] w_slice0;
    logic [OUT_W-1:0] w_slice1;
    logic             w_unusedData;

    assign w_slice0     = inp_0d[LOW0 +: OUT_W];
    assign w_slice1     = inp_0d[LOW1 +: OUT_W];
    assign w_unusedData = ^inp_0d;
    assign w_grantReq   = r_grant ? out1_0r : out0_0r;

    brz_rr_pick u_pick (
        .req   ({out1_0r, out0_0r}),
        .last  (r_last),
        .valid (w_pickValid),
        .idx   (w_pickIdx)
    );

    // State register plus registered control outputs, all async-cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_inpReq <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_busy   <= 1'b0;
            r_grant  <= 1'b0;
            r_last   <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_inpReq <= w_inpReqNext;
            r_ack0   <= w_ack0Next;
            r_ack1   <= w_ack1Next;
            r_busy   <= w_busyNext;
            r_grant  <= w_grantNext;
            r_last   <= w_lastNext;
            r_cnt    <= w_cntNext;
        end
    end

    // Next-state: walk the four handshake phases of one transaction.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_pickValid) w_stateNext = FETCH;
            FETCH:   if (inp_0a)      w_stateNext = ACK;
            ACK:     if (!w_grantReq) w_stateNext = RTZ;
            RTZ:     if (!inp_0a)     w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Output logic: next values for the registered handshake and status outputs.
    always_comb begin
        w_inpReqNext = r_inpReq;
        w_ack0Next   = r_ack0;
        w_ack1Next   = r_ack1;
        w_busyNext   = r_busy;
        w_grantNext  = r_grant;
        w_lastNext   = r_last;
        w_cntNext    = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_pickValid) begin
                    w_inpReqNext = 1'b1;
                    w_busyNext   = 1'b1;
                    w_grantNext  = w_pickIdx;
                end
            end
            FETCH: begin
                if (inp_0a) begin
                    w_ack0Next = (r_grant == 1'b0);
                    w_ack1Next = (r_grant == 1'b1);
`ifdef BRZ_SLICE_CAPTURE_EN
                    w_inpReqNext = 1'b0;
`endif
                end
            end
            ACK: begin
                if (!w_grantReq) begin
                    w_ack0Next   = 1'b0;
                    w_ack1Next   = 1'b0;
                    w_inpReqNext = 1'b0;
                end
            end
            RTZ: begin
                if (!inp_0a) begin
                    w_busyNext = 1'b0;
                    w_lastNext = r_grant;
                    w_cntNext  = r_cnt + 1'b1;
                end
            end
            default: begin
                w_inpReqNext = 1'b0;
                w_ack0Next   = 1'b0;
                w_ack1Next   = 1'b0;
                w_busyNext   = 1'b0;
            end
        endcase
    end

`ifdef BRZ_SLICE_CAPTURE_EN
    logic [OUT_W-1:0] r_data0;
    logic [OUT_W-1:0] r_data1;

    // Capture both slices as the producer acknowledges, so it may move on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data0 <= '0;
            r_data1 <= '0;
        end else if (r_state == FETCH && inp_0a) begin
            r_data0 <= w_slice0;
            r_data1 <= w_slice1;
        end
    end

    assign out0_0d = r_data0;
    assign out1_0d = r_data1;
`else
    assign out0_0d = w_slice0;
    assign out1_0d = w_slice1;
`endif

    assign inp_0r   = r_inpReq;
    assign out0_0a  = r_ack0;
    assign out1_0a  = r_ack1;
    assign busy     = r_busy;
    assign grant    = r_grant;
    assign xfer_cnt = r_cnt;

endmodule

// File: tb/tb_brz_slice_arbiter.sv
// Directed, scoreboard-based bench for brz_slice_arbiter with a 2-bit
// transfer counter so that counter wrap is exercised.
// Honours BRZ_SLICE_CAPTURE_EN for the capture-specific checks.
module tb_brz_slice_arbiter;

    localparam int IN_W  = 18;
    localparam int OUT_W = 16;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic [31:0]      grant;
        logic [OUT_W-1:0] data;
    } exp_t;

    logic             clock;
    logic             rst_n;
    logic             out0_0r;
    logic             out0_0a;
    logic [OUT_W-1:0] out0_0d;
    logic             out1_0r;
    logic             out1_0a;
    logic [OUT_W-1:0] out1_0d;
    logic             inp_0r;
    logic             inp_0a;
    logic [IN_W-1:0]  inp_0d;
    logic             busy;
    logic             grant;
    logic [CNT_W-1:0] xfer_cnt;

    exp_t sbQueue[$];
    int   compared;
    int   mismatched;
    int   modelCnt;

    brz_slice_arbiter #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .LOW0  (1),
        .LOW1  (0),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clock),
        .rst_n    (rst_n),
        .out0_0r  (out0_0r),
        .out0_0a  (out0_0a),
        .out0_0d  (out0_0d),
        .out1_0r  (out1_0r),
        .out1_0a  (out1_0a),
        .out1_0d  (out1_0d),
        .inp_0r   (inp_0r),
        .inp_0a   (inp_0a),
        .inp_0d   (inp_0d),
        .busy     (busy),
        .grant    (grant),
        .xfer_cnt (xfer_cnt)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case a handshake never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyReset();
        rst_n   = 1'b0;
        out0_0r = 1'b0;
        out1_0r = 1'b0;
        inp_0a  = 1'b0;
        inp_0d  = '0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        modelCnt = 0;
        sbQueue.delete();
    endtask

    // One full transaction for the expected consumer, acting as producer.
    task automatic applyStimulus(input logic [IN_W-1:0] data, input int expGrant,
                                 input bit keepReq, input bit resetInAck);
        exp_t             e;
        int               n;
        logic             ackG;
        logic [OUT_W-1:0] dataG;

        n = 0;
        while (inp_0r !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checkOutput("fetchReq", 32'(inp_0r), 32'd1);
        checkOutput("fetchBusy", 32'(busy), 32'd1);
        checkOutput("fetchGrant", 32'(grant), 32'(expGrant));

        repeat (2) @(negedge clock);
        e.grant = 32'(expGrant);
        e.data  = (expGrant == 0) ? OUT_W'(data >> 1) : OUT_W'(data);
        sbQueue.push_back(e);
        inp_0a = 1'b1;
        inp_0d = data;

        n = 0;
        ackG = (expGrant == 0) ? out0_0a : out1_0a;
        while (ackG !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
            ackG = (expGrant == 0) ? out0_0a : out1_0a;
        end
        checkOutput("ackRise", 32'(ackG), 32'd1);
        e = sbQueue.pop_front();
        dataG = (e.grant == 0) ? out0_0d : out1_0d;
        checkOutput("sliceData", 32'(dataG), 32'(e.data));
        checkOutput("otherAck", 32'((e.grant == 0) ? out1_0a : out0_0a), 32'd0);
`ifdef BRZ_SLICE_CAPTURE_EN
        checkOutput("earlyRelease", 32'(inp_0r), 32'd0);
        inp_0d = ~data;
        @(negedge clock);
        dataG = (e.grant == 0) ? out0_0d : out1_0d;
        checkOutput("heldData", 32'(dataG), 32'(e.data));
`else
        checkOutput("reqHeldInAck", 32'(inp_0r), 32'd1);
`endif

        if (resetInAck) begin
            rst_n = 1'b0;
            #1;
            checkOutput("rstAck0", 32'(out0_0a), 32'd0);
            checkOutput("rstInpReq", 32'(inp_0r), 32'd0);
            checkOutput("rstBusy", 32'(busy), 32'd0);
            checkOutput("rstCnt", 32'(xfer_cnt), 32'd0);
            out0_0r  = 1'b0;
            out1_0r  = 1'b0;
            inp_0a   = 1'b0;
            modelCnt = 0;
            @(negedge clock);
            rst_n = 1'b1;
            @(negedge clock);
            return;
        end

        if (expGrant == 0) out0_0r = 1'b0;
        else               out1_0r = 1'b0;

        n = 0;
        ackG = (expGrant == 0) ? out0_0a : out1_0a;
        while ((inp_0r !== 1'b0 || ackG !== 1'b0) && n < 20) begin
            @(negedge clock);
            n++;
            ackG = (expGrant == 0) ? out0_0a : out1_0a;
        end
        checkOutput("ackFall", 32'(ackG), 32'd0);
        checkOutput("reqFall", 32'(inp_0r), 32'd0);
        inp_0a = 1'b0;
        if (keepReq) begin
            if (expGrant == 0) out0_0r = 1'b1;
            else               out1_0r = 1'b1;
        end

        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checkOutput("idleBusy", 32'(busy), 32'd0);
        modelCnt = (modelCnt + 1) % (1 << CNT_W);
        checkOutput("xferCnt", 32'(xfer_cnt), 32'(modelCnt));
    endtask

    initial begin
        logic [IN_W-1:0] dataTab [6];
        compared   = 0;
        mismatched = 0;
        modelCnt   = 0;
        dataTab[0] = 18'h3FFFF;
        dataTab[1] = 18'h00000;
        dataTab[2] = 18'h12345;
        dataTab[3] = 18'h2DCBA;
        dataTab[4] = 18'h15555;
        dataTab[5] = 18'h2AAAB;

        // Reset values.
        applyReset();
        checkOutput("resetInpReq", 32'(inp_0r), 32'd0);
        checkOutput("resetAck0", 32'(out0_0a), 32'd0);
        checkOutput("resetAck1", 32'(out1_0a), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetGrant", 32'(grant), 32'd0);
        checkOutput("resetCnt", 32'(xfer_cnt), 32'd0);
`ifdef BRZ_SLICE_CAPTURE_EN
        checkOutput("resetData0", 32'(out0_0d), 32'd0);
`endif

        // Single consumer 0 transaction.
        out0_0r = 1'b1;
        applyStimulus(18'h2AAAB, 0, 1'b0, 1'b0);
        checkOutput("firstCnt", 32'(xfer_cnt), 32'd1);

        // Simultaneous requests after reset: consumer 0 first, then 1.
        applyReset();
        out0_0r = 1'b1;
        out1_0r = 1'b1;
        applyStimulus(18'h2AAAB, 0, 1'b0, 1'b0);
        applyStimulus(18'h2AAAB, 1, 1'b0, 1'b0);

        // Both held requesting: grants alternate, counter wraps at 2 bits.
        applyReset();
        out0_0r = 1'b1;
        out1_0r = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(dataTab[i], i % 2, 1'b1, 1'b0);
        end

        // Reset in the ACK phase, then a normal transaction.
        applyReset();
        out0_0r = 1'b1;
        applyStimulus(18'h1F0F0, 0, 1'b0, 1'b1);
        out0_0r = 1'b1;
        applyStimulus(18'h0ABCD, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
